csu_sequencer: RTL and testbench
================================

// Module: csu_sequencer
// PURPOSE
//  Digital controller for the current-source-unit array (17 thermometer cells, 6 binary cells, 1 redundant LSB).
//  Owns the power-up, settle, code-update, testbus-scan, power-down and fault sequence.
//  Drives pdb, atb_ena and the per-cell switch enables of the analog array.
//  Applies a new 11-bit code (therm = code[10:6], bin = code[5:0]) glitch-safely by ramping thermometer cells one unit at a time.
// PARAMETERS
//  PWRUP_CYCLES  64  cycles pdb is held high with all cells off before the first code may be applied
//  RAMP_CYCLES   4   cycles between successive single-unit thermometer steps (>=1)
//  ATB_DWELL     16  cycles each atb_ena setting is held during a testbus scan (>=1)
// PORTS
//  clk           in   1   block clock
//  rst           in   1   synchronous, active-high reset
//  en            in   1   level; 1 = array requested on, 0 = power down
//  supply_ok     in   1   level from supply/iref monitor; 0 = out-of-range input
//  code_valid    in   1   code handshake valid
//  code          in   11  requested output code, 0..1151 legal
//  red_sel       in   1   1 = use redundant LSB cell instead of bin cell 0 (sampled on accept)
//  atb_scan_req  in   1   single-cycle pulse requesting a testbus scan
//  code_ready    out  1   code handshake ready
//  pdb           out  1   power-down-bar to the array
//  atb_ena       out  2   testbus select to the array
//  therm_en      out  17  thermometer cell enables, LSB-first fill
//  bin_en        out  6   binary cell enables (bit5 = MSB cell)
//  bin_red_en    out  1   redundant LSB cell enable
//  settled       out  1   1 = ACTIVE and the thermometer count equals its target
//  sat           out  1   1 = last accepted code was >1151 and was clipped
//  fault         out  1   1 = in FAULT
// BEHAVIOUR
//  Reset:
//   - Every output is 0; state = OFF; internal therm_cnt = target = 0.
//   - All outputs are registered; the response to any input lands on the next clk edge.
//  States: OFF, PWRUP, ACTIVE, SCAN, PWRDN, FAULT.
//  Transition priority: rst > supply_ok==0 > en==0 > code accept > scan request.
//  OFF:
//   - pdb=0, all enables 0.
//   - en&&supply_ok -> PWRUP, cycle counter cleared.
//  PWRUP:
//   - pdb=1, all enables 0.
//   - After exactly PWRUP_CYCLES cycles in PWRUP -> ACTIVE.
//   - en==0 -> OFF.
//  ACTIVE:
//   - code_ready = (therm_cnt==target).
//   - Accept on code_valid&&code_ready:
//     - target = code[10:6] clipped to 17.
//     - bin_en = code[5:0], or 6'h3F if code>1151; sat updated on accept.
//     - red_sel=1: bin_en[0]=0 and bin_red_en = selected LSB; red_sel=0: bin_red_en=0.
//     - bin_en and bin_red_en update on the cycle after accept.
//   - Ramp: therm_cnt moves +/-1 toward target every RAMP_CYCLES cycles; the first step occurs RAMP_CYCLES cycles after accept.
//   - therm_en = (1<<therm_cnt)-1.
//   - atb_scan_req while settled -> SCAN. A request while ramping, or in the same cycle as an accept, is dropped (not queued).
//  SCAN:
//   - atb_ena = 01, 10, 11, each held ATB_DWELL cycles, then 00 and -> ACTIVE.
//   - code_ready=0; therm_en and bin_en frozen.
//  PWRDN (entered from ACTIVE or SCAN on en==0):
//   - atb_ena=00, bin_en=0, bin_red_en=0 and code_ready=0 on entry.
//   - therm_cnt ramps to 0 at the RAMP_CYCLES rate, even if a ramp is in progress.
//   - When therm_cnt==0 -> OFF; pdb drops on the following cycle.
//   - en returning high during PWRDN is ignored until OFF is reached.
//  FAULT (supply_ok==0 in any state except OFF/FAULT):
//   - Next cycle: pdb=0, atb_ena=00, all enables 0, code_ready=0, therm_cnt=target=0, fault=1.
//   - Exit to OFF only when en==0; fault clears then.
//   - supply_ok==0 in OFF has no effect.
//  Reset mid-operation:
//   - All outputs drop to 0 on the next edge.
//   - No ramp-down is performed on reset.
// TESTING
//  - Power-up: rst, then en=1, supply_ok=1 -> pdb=1 next cycle; code_ready rises exactly 64 cycles later; enables 0 throughout.
//  - Ramp: accept code=11'd200 (target 3, bin 8) with RAMP_CYCLES=4 -> bin_en=6'd8 at accept+1; therm_en 1,3,7 at accept+4,+8,+12; settled at +12.
//  - Saturation/redundancy: code=11'd2047, red_sel=1 -> therm_en=17'h1FFFF after ramp, bin_en=6'h3E, bin_red_en=1, sat=1.
//  - Scan: settled, atb_scan_req pulse -> atb_ena 01/10/11 for 16 cycles each, then 00; code_ready=0 throughout the scan.
//  - Power-down: therm_cnt=5, en=0 -> bin_en=0 next cycle; therm_en steps down to 0 over 20 cycles; pdb=0 one cycle later.
//  - Fault: during a ramp, supply_ok=0 for 1 cycle -> all outputs 0 and fault=1 next cycle; fault stays 1 until en=0.

Source files
------------

// File: rtl/csu_sequencer_if.sv
// Code handshake between the DAC code source and the CSU sequencer.
//   code_valid  source -> sequencer  new code offered this cycle
//   code        source -> sequencer  11-bit requested code (therm = [10:6], bin = [5:0])
//   red_sel     source -> sequencer  steer the binary LSB onto the redundant cell
//   code_ready  sequencer -> source  sequencer can take a new code this cycle
// The sequencer side uses the slave modport; whoever drives codes uses master.
interface csu_sequencer_if;
  logic        code_valid;
  logic [10:0] code;
  logic        red_sel;
  logic        code_ready;

  modport master (
    output code_valid,
    output code,
    output red_sel,
    input  code_ready
  );

  modport slave (
    input  code_valid,
    input  code,
    input  red_sel,
    output code_ready
  );
endinterface

// File: rtl/csu_sequencer.sv
// Sequencer for the current-source-unit array (17 thermometer cells,
// 6 binary cells, 1 redundant LSB cell). Handles power-up settling,
// glitch-safe code updates (thermometer cells move one unit at a time),
// testbus scans, ramped power-down and supply faults.
//
// Ports
//   clk, rst      block clock, synchronous active-high reset
//   en            1 = array requested on, 0 = power down
//   supply_ok     supply/iref monitor, 0 = out of range
//   code_if       code handshake (valid/code/red_sel in, ready out)
//   atb_scan_req  single-cycle testbus scan request
//   pdb           power-down-bar to the array
//   atb_ena       testbus select
//   therm_en      thermometer cell enables, filled from bit 0 upward
//   bin_en        binary cell enables, bit 5 = MSB cell
//   bin_red_en    redundant LSB cell enable
//   settled       ACTIVE and thermometer count at its target
//   sat           last accepted code was above 1151 and was clipped
//   fault         sequencer is in FAULT
//
// Every output is a flop; each is loaded from the next-state values so the
// outputs always describe the state the block is in during that cycle.
module csu_sequencer #(
  parameter int PWRUP_CYCLES = 64,
  parameter int RAMP_CYCLES  = 4,
  parameter int ATB_DWELL    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  supply_ok,
  csu_sequencer_if.slave        code_if,
  input  logic                  atb_scan_req,
  output logic                  pdb,
  output logic [1:0]            atb_ena,
  output logic [16:0]           therm_en,
  output logic [5:0]            bin_en,
  output logic                  bin_red_en,
  output logic                  settled,
  output logic                  sat,
  output logic                  fault
);

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_PWRUP  = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_PWRDN  = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam logic [4:0] THERM_MAX = 5'd17;

  // One cycle counter serves both the power-up wait and the scan dwell.
  localparam int CYC_MAX = (PWRUP_CYCLES > ATB_DWELL) ? PWRUP_CYCLES : ATB_DWELL;
  localparam int CW      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int RW      = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;

  localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(ATB_DWELL - 1);
  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_CYCLES - 1);

  logic [2:0]    state,     state_n;
  logic [CW-1:0] cyc_cnt,   cyc_n;
  logic [RW-1:0] ramp_cnt,  ramp_n;
  logic [4:0]    therm_cnt, therm_n;
  logic [4:0]    target,    target_n;
  logic [1:0]    atb_n;
  logic [5:0]    bin_n;
  logic          red_n;
  logic          sat_n;
  logic          fault_n;
  logic          settled_n;
  logic [16:0]   therm_dec;

  logic          do_ramp;
  logic          ramp_restart;
  logic          pwrdn_entry;
  logic [RW-1:0] ramp_base;

  logic [4:0]    req_therm;
  logic          req_over;
  logic [5:0]    req_bin;

  // Codes above 1151 have a thermometer field of 18 or more; those clip to
  // full scale on both the thermometer and the binary half.
  assign req_therm = code_if.code[10:6];
  assign req_over  = (req_therm > THERM_MAX);
  assign req_bin   = req_over ? 6'h3F : code_if.code[5:0];

  // In ACTIVE, ready and settled are the same condition; elsewhere both are 0.
  assign code_if.code_ready = settled;

  always_comb begin
    state_n      = state;
    cyc_n        = cyc_cnt;
    ramp_n       = ramp_cnt;
    therm_n      = therm_cnt;
    target_n     = target;
    atb_n        = atb_ena;
    bin_n        = bin_en;
    red_n        = bin_red_en;
    sat_n        = sat;
    fault_n      = fault;
    do_ramp      = 1'b0;
    ramp_restart = 1'b0;
    pwrdn_entry  = 1'b0;
    ramp_base    = ramp_cnt;

    case (state)
      S_OFF: begin
        if (en && supply_ok) begin
          state_n = S_PWRUP;
          cyc_n   = '0;
        end
      end

      S_PWRUP: begin
        if (!supply_ok) begin
          state_n = S_FAULT;
        end else if (!en) begin
          state_n = S_OFF;
        end else if (cyc_cnt == PWRUP_LAST) begin
          state_n = S_ACTIVE;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_cnt + 1'b1;
        end
      end

      S_ACTIVE: begin
        if (!supply_ok) begin
          state_n = S_FAULT;
        end else if (!en) begin
          pwrdn_entry = 1'b1;
        end else begin
          do_ramp = 1'b1;
          // An accept wins over a scan request in the same cycle; the
          // request is simply dropped.
          if (code_if.code_valid && settled) begin
            ramp_restart = 1'b1;
            target_n     = req_over ? THERM_MAX : req_therm;
            sat_n        = req_over;
            if (code_if.red_sel) begin
              bin_n = {req_bin[5:1], 1'b0};
              red_n = req_bin[0];
            end else begin
              bin_n = req_bin;
              red_n = 1'b0;
            end
          end else if (atb_scan_req && settled) begin
            state_n = S_SCAN;
            atb_n   = 2'b01;
            cyc_n   = '0;
            do_ramp = 1'b0;
          end
        end
      end

      S_SCAN: begin
        if (!supply_ok) begin
          state_n = S_FAULT;
        end else if (!en) begin
          pwrdn_entry = 1'b1;
        end else if (cyc_cnt == DWELL_LAST) begin
          cyc_n = '0;
          if (atb_ena == 2'b11) begin
            atb_n   = 2'b00;
            state_n = S_ACTIVE;
          end else begin
            atb_n = atb_ena + 2'b01;
          end
        end else begin
          cyc_n = cyc_cnt + 1'b1;
        end
      end

      S_PWRDN: begin
        // OFF is taken only once the count already sits at zero, so pdb
        // falls one cycle after the last thermometer cell switches off.
        if (!supply_ok) begin
          state_n = S_FAULT;
        end else if (therm_cnt == 5'd0) begin
          state_n = S_OFF;
        end else begin
          do_ramp = 1'b1;
        end
      end

      S_FAULT: begin
        if (!en) begin
          state_n = S_OFF;
          fault_n = 1'b0;
        end
      end

      default: begin
        state_n = S_OFF;
      end
    endcase

    // Power-down retargets to zero and restarts the ramp timer, abandoning
    // any ramp that was in flight.
    if (pwrdn_entry) begin
      state_n      = S_PWRDN;
      target_n     = 5'd0;
      atb_n        = 2'b00;
      bin_n        = 6'd0;
      red_n        = 1'b0;
      do_ramp      = 1'b1;
      ramp_restart = 1'b1;
    end

    // The ramp timer counts the cycles since the last step (or since the
    // accept / power-down entry, which counts as cycle one), and a step is
    // taken on the edge that closes the RAMP_CYCLES-th cycle.
    if (do_ramp) begin
      ramp_base = ramp_restart ? '0 : ramp_cnt;
      if (therm_cnt == target_n) begin
        ramp_n = '0;
      end else if (ramp_base == RAMP_LAST) begin
        ramp_n  = '0;
        therm_n = (therm_cnt < target_n) ? therm_cnt + 5'd1 : therm_cnt - 5'd1;
      end else begin
        ramp_n = ramp_base + 1'b1;
      end
    end

    // Fault entry: drop the whole array at once, no ramp.
    if ((state_n == S_FAULT) && (state != S_FAULT)) begin
      therm_n  = 5'd0;
      target_n = 5'd0;
      ramp_n   = '0;
      atb_n    = 2'b00;
      bin_n    = 6'd0;
      red_n    = 1'b0;
      sat_n    = 1'b0;
      fault_n  = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 17; i++) begin
      therm_dec[i] = (therm_n > 5'(i));
    end
  end

  assign settled_n = (state_n == S_ACTIVE) && (therm_n == target_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_OFF;
      cyc_cnt    <= '0;
      ramp_cnt   <= '0;
      therm_cnt  <= 5'd0;
      target     <= 5'd0;
      pdb        <= 1'b0;
      atb_ena    <= 2'b00;
      therm_en   <= 17'd0;
      bin_en     <= 6'd0;
      bin_red_en <= 1'b0;
      settled    <= 1'b0;
      sat        <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      cyc_cnt    <= cyc_n;
      ramp_cnt   <= ramp_n;
      therm_cnt  <= therm_n;
      target     <= target_n;
      pdb        <= (state_n != S_OFF) && (state_n != S_FAULT);
      atb_ena    <= atb_n;
      therm_en   <= therm_dec;
      bin_en     <= bin_n;
      bin_red_en <= red_n;
      settled    <= settled_n;
      sat        <= sat_n;
      fault      <= fault_n;
    end
  end

endmodule

// File: tb/tb_csu_sequencer.sv
// Self-checking bench for csu_sequencer. A timeline model predicts each
// output from the number of cycles elapsed since an accept, scan request or
// power-down, using plain arithmetic on the code values.
module tb_csu_sequencer;
  localparam int PWRUP = 64;
  localparam int RAMP  = 4;
  localparam int DWELL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        supply_ok;
  logic        atb_scan_req;
  logic        pdb;
  logic [1:0]  atb_ena;
  logic [16:0] therm_en;
  logic [5:0]  bin_en;
  logic        bin_red_en;
  logic        settled;
  logic        sat;
  logic        fault;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int model_therm = 0;
  int rnd_code;
  int rnd_mode;
  logic rnd_red;

  csu_sequencer_if code_if();

  csu_sequencer #(
    .PWRUP_CYCLES(PWRUP),
    .RAMP_CYCLES (RAMP),
    .ATB_DWELL   (DWELL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .supply_ok   (supply_ok),
    .code_if     (code_if),
    .atb_scan_req(atb_scan_req),
    .pdb         (pdb),
    .atb_ena     (atb_ena),
    .therm_en    (therm_en),
    .bin_en      (bin_en),
    .bin_red_en  (bin_red_en),
    .settled     (settled),
    .sat         (sat),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks = n_checks + 1;
    assert (observed === expected) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v_valid, input logic [10:0] v_code,
                               input logic v_red, input logic v_scan);
    code_if.code_valid = v_valid;
    code_if.code       = v_code;
    code_if.red_sel    = v_red;
    atb_scan_req       = v_scan;
    nextCycle();
    code_if.code_valid = 1'b0;
    atb_scan_req       = 1'b0;
  endtask

  function automatic logic [31:0] outVec();
    return {1'b0, pdb, atb_ena, therm_en, bin_en, bin_red_en,
            code_if.code_ready, settled, sat, fault};
  endfunction

  function automatic logic [16:0] thermMask(input int n);
    logic [31:0] one;
    one = 32'd1;
    return 17'((one << n) - 32'd1);
  endfunction

  function automatic int modelTarget(input int c);
    return (c / 64 > 17) ? 17 : c / 64;
  endfunction

  task automatic powerUp(input string tag);
    int   cyc;
    logic en_seen;
    en = 1'b1;
    supply_ok = 1'b1;
    nextCycle();
    cyc = 1;
    en_seen = 1'b0;
    checkOutput({tag, "/pdb"}, 32'(pdb), 32'd1);
    while (code_if.code_ready !== 1'b1 && cyc < 200) begin
      if (therm_en !== 17'd0 || bin_en !== 6'd0 || bin_red_en !== 1'b0 ||
          atb_ena !== 2'd0 || pdb !== 1'b1)
        en_seen = 1'b1;
      nextCycle();
      cyc++;
    end
    checkOutput({tag, "/latency"}, 32'(cyc - 1), 32'(PWRUP));
    checkOutput({tag, "/quiet"}, 32'(en_seen), 32'd0);
    checkOutput({tag, "/settled"}, 32'(settled), 32'd1);
    model_therm = 0;
  endtask

  // Called in the first cycle after the accept edge; ends in the cycle where
  // the thermometer count first equals the target.
  task automatic followRamp(input int start, input int tgt, input logic scan_pulse,
                            input string tag);
    int delta, dir, total, steps, expc;
    delta = (tgt > start) ? tgt - start : start - tgt;
    dir   = (tgt > start) ? 1 : -1;
    total = (delta * RAMP < 1) ? 1 : delta * RAMP;
    for (int k = 1; k <= total; k++) begin
      steps = (k / RAMP > delta) ? delta : k / RAMP;
      expc  = start + dir * steps;
      checkOutput({tag, "/therm"}, 32'(therm_en), 32'(thermMask(expc)));
      checkOutput({tag, "/settled"}, 32'(settled), 32'(steps == delta));
      checkOutput({tag, "/ready"}, 32'(code_if.code_ready), 32'(steps == delta));
      checkOutput({tag, "/atb"}, 32'(atb_ena), 32'd0);
      if (k < total) begin
        if (k == 1) atb_scan_req = scan_pulse;
        nextCycle();
        atb_scan_req = 1'b0;
      end
    end
  endtask

  // scan_mode: 0 none, 1 scan request in the accept cycle, 2 request mid-ramp
  task automatic doAccept(input int c, input logic red, input int scan_mode,
                          input string tag);
    int tgt, b;
    logic [5:0] eb;
    logic er;
    tgt = modelTarget(c);
    b   = (c > 1151) ? 63 : c % 64;
    eb  = red ? 6'(b - b % 2) : 6'(b);
    er  = red ? 1'(b % 2) : 1'b0;
    checkOutput({tag, "/ready_pre"}, 32'(code_if.code_ready), 32'd1);
    applyStimulus(1'b1, 11'(c), red, scan_mode == 1);
    checkOutput({tag, "/bin"}, 32'(bin_en), 32'(eb));
    checkOutput({tag, "/red"}, 32'(bin_red_en), 32'(er));
    checkOutput({tag, "/sat"}, 32'(sat), 32'(c > 1151));
    followRamp(model_therm, tgt, scan_mode == 2, tag);
    model_therm = tgt;
  endtask

  task automatic doScan(input string tag);
    int expa;
    checkOutput({tag, "/settled_pre"}, 32'(settled), 32'd1);
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 3 * DWELL + 1; k++) begin
      expa = (k <= 3 * DWELL) ? (k - 1) / DWELL + 1 : 0;
      checkOutput({tag, "/atb"}, 32'(atb_ena), 32'(expa));
      checkOutput({tag, "/ready"}, 32'(code_if.code_ready), 32'(k > 3 * DWELL));
      if (k == 2 * DWELL)
        checkOutput({tag, "/therm_frozen"}, 32'(therm_en), 32'(thermMask(model_therm)));
      if (k < 3 * DWELL + 1) nextCycle();
    end
  endtask

  task automatic powerDown(input string tag);
    int start, last, steps;
    start = model_therm;
    last  = (start * RAMP < 1) ? 1 : start * RAMP;
    en = 1'b0;
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
    for (int k = 1; k <= last + 1; k++) begin
      steps = (k / RAMP > start) ? start : k / RAMP;
      checkOutput({tag, "/therm"}, 32'(therm_en), 32'(thermMask(start - steps)));
      checkOutput({tag, "/bin"}, 32'({bin_red_en, bin_en}), 32'd0);
      checkOutput({tag, "/ready"}, 32'(code_if.code_ready), 32'd0);
      checkOutput({tag, "/pdb"}, 32'(pdb), 32'(k <= last));
      if (k < last + 1) nextCycle();
    end
    model_therm = 0;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    supply_ok = 1'b1;
    atb_scan_req = 1'b0;
    code_if.code_valid = 1'b0;
    code_if.code = 11'd0;
    code_if.red_sel = 1'b0;
    repeat (3) nextCycle();
    checkOutput("reset", outVec(), 32'd0);
    rst = 1'b0;
    nextCycle();
    checkOutput("off_idle", outVec(), 32'd0);

    en = 1'b1;
    supply_ok = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("off_supply_low", outVec(), 32'd0);
    en = 1'b0;
    supply_ok = 1'b1;
    nextCycle();

    powerUp("pwrup1");
    doAccept(200, 1'b0, 0, "ramp200");
    doScan("scan1");
    doAccept(2047, 1'b1, 0, "sat_red");
    checkOutput("sat_therm_full", 32'(therm_en), 32'h1FFFF);
    doAccept(1151, 1'b0, 0, "edge1151");
    doAccept(1152, 1'b1, 0, "edge1152");
    doAccept(640, 1'b0, 2, "scan_drop_ramp");
    doAccept(100, 1'b1, 1, "scan_drop_accept");

    for (int i = 0; i < 14; i++) begin
      rnd_code = int'($urandom_range(0, 2047));
      rnd_red  = 1'($urandom_range(0, 1));
      rnd_mode = int'($urandom_range(0, 2));
      doAccept(rnd_code, rnd_red, rnd_mode, "rand");
      if (i % 4 == 3) doScan("rand_scan");
    end

    doAccept(5 * 64 + 9, 1'b0, 0, "pd_setup");
    powerDown("pwrdn");
    checkOutput("pwrdn_off", outVec(), 32'd0);

    powerUp("pwrup2");
    applyStimulus(1'b1, 11'd768, 1'b0, 1'b0);
    repeat (4) nextCycle();
    checkOutput("fault_pre_therm", 32'(therm_en), 32'(thermMask(1)));
    supply_ok = 1'b0;
    nextCycle();
    supply_ok = 1'b1;
    checkOutput("fault_entry", outVec(), 32'h1);
    repeat (5) nextCycle();
    checkOutput("fault_hold", outVec(), 32'h1);
    en = 1'b0;
    nextCycle();
    checkOutput("fault_exit", outVec(), 32'd0);
    model_therm = 0;
    nextCycle();

    powerUp("pwrup3");
    doAccept(300, 1'b0, 0, "post_fault");
    applyStimulus(1'b1, 11'd1000, 1'b0, 1'b0);
    repeat (5) nextCycle();
    rst = 1'b1;
    nextCycle();
    checkOutput("reset_midop", outVec(), 32'd0);
    en = 1'b0;
    rst = 1'b0;
    nextCycle();
    checkOutput("after_reset", outVec(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
